// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, NOP bubbles and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to add the second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
   parameter int DW    = 96,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           stateQ, stateD;
   logic [DW-1:0]    mQ, mD;
   logic [CNT_W-1:0] cntQ;
   logic             accept;
   logic             fire;

`ifdef PIPE_STAGE_SKID_EN
   logic [DW-1:0]    sQ, sD;

   // Depends only on held state and reset, so out_ready never reaches in_ready.
   assign in_ready = (stateQ != FULL) && !reset;
`else
   assign in_ready = (!out_valid || out_ready) && !reset;
`endif

   assign out_valid  = (stateQ != EMPTY);
   assign out_data   = mQ;
   assign bubble_cnt = cntQ;
   assign accept     = in_valid && in_ready;
   assign fire       = out_valid && out_ready;

   always_comb begin
      stateD = stateQ;
      mD     = mQ;
`ifdef PIPE_STAGE_SKID_EN
      sD     = sQ;
`endif
      unique case (stateQ)
         EMPTY: begin
            if (accept) begin
               stateD = ONE;
               mD     = in_data;
            end
         end
         ONE: begin
            if (accept && fire) begin
               mD = in_data;
`ifdef PIPE_STAGE_SKID_EN
            end else if (accept) begin
               stateD = FULL;
               sD     = in_data;
`endif
            end else if (fire) begin
               stateD = EMPTY;
               mD     = '0;
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         FULL: begin
            if (fire) begin
               stateD = ONE;
               mD     = sQ;
               sD     = '0;
            end
         end
`endif
         default: begin
            stateD = EMPTY;
            mD     = '0;
         end
      endcase
      // Flush wins over every transition; empty entries stay zero so bubbles are NOPs.
      if (flush) begin
         stateD = EMPTY;
         mD     = '0;
`ifdef PIPE_STAGE_SKID_EN
         sD     = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= EMPTY;
         mQ     <= '0;
`ifdef PIPE_STAGE_SKID_EN
         sQ     <= '0;
`endif
      end else begin
         stateQ <= stateD;
         mQ     <= mD;
`ifdef PIPE_STAGE_SKID_EN
         sQ     <= sD;
`endif
      end
   end

   // Idle-cycle counter: only reset clears it, it sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         cntQ <= '0;
      end else if (out_ready && !out_valid && !(&cntQ)) begin
         cntQ <= cntQ + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the stimulus sequence.
module tb_pipe_stage_reg;

   localparam int DW    = 16;
   localparam int CNT_W = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP   = 2;
`else
   localparam int CAP   = 1;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [CNT_W-1:0] bubble_cnt;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] modelQ[$];
   int            modelCnt   = 0;
   bit            modelValid = 1'b0;

   pipe_stage_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   // Expected in_ready derived from queue occupancy and the current inputs.
   function automatic logic modelReady();
      if (reset) return 1'b0;
      if (CAP == 2) return (modelQ.size() < 2);
      return (modelQ.size() == 0) || out_ready;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                input logic [DW-1:0] d, input logic ordy);
      @(posedge clk);
      #1;
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   // Reference model: a FIFO of capacity CAP updated at every rising edge.
   always @(posedge clk) begin
      logic acc, fr;
      if (reset) begin
         modelQ.delete();
         modelCnt   = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         acc = in_valid && modelReady();
         fr  = (modelQ.size() > 0) && out_ready;
         if (out_ready && modelQ.size() == 0 && modelCnt < (1 << CNT_W) - 1)
            modelCnt++;
         if (flush) begin
            modelQ.delete();
         end else begin
            if (fr) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("cyc_out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
         checkOutput("cyc_out_data", 32'(out_data), (modelQ.size() > 0) ? 32'(modelQ[0]) : 32'd0);
         checkOutput("cyc_in_ready", 32'(in_ready), 32'(modelReady()));
         checkOutput("cyc_bubble_cnt", 32'(bubble_cnt), 32'(modelCnt));
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'hABC; out_ready = 1'b0;

      // Reset held two cycles with a live input offer.
      applyStimulus(1, 0, 1, 16'hABC, 0);
      applyStimulus(1, 0, 1, 16'hABC, 0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rel_out_valid", 32'(out_valid), 32'd0);

      // Streaming 1..4 with one-cycle latency.
      applyStimulus(0, 0, 1, 16'd1, 0);
      applyStimulus(0, 0, 1, 16'd2, 1);
      checkOutput("str_d1", 32'(out_data), 32'd1);
      applyStimulus(0, 0, 1, 16'd3, 1);
      checkOutput("str_d2", 32'(out_data), 32'd2);
      applyStimulus(0, 0, 1, 16'd4, 1);
      checkOutput("str_d3", 32'(out_data), 32'd3);
      applyStimulus(0, 0, 0, 16'd0, 1);
      checkOutput("str_d4", 32'(out_data), 32'd4);
      checkOutput("str_v4", 32'(out_valid), 32'd1);
      applyStimulus(0, 0, 0, 16'd0, 0);
      checkOutput("str_empty", 32'(out_valid), 32'd0);
      checkOutput("str_bubbles", 32'(bubble_cnt), 32'd0);

`ifdef PIPE_STAGE_SKID_EN
      // Back-pressure: 11 lands in the skid entry, 12 waits upstream.
      applyStimulus(0, 0, 1, 16'd10, 0);
      applyStimulus(0, 0, 1, 16'd11, 0);
      checkOutput("bp_ready_one", 32'(in_ready), 32'd1);
      applyStimulus(0, 0, 1, 16'd12, 0);
      checkOutput("bp_ready_full", 32'(in_ready), 32'd0);
      checkOutput("bp_head", 32'(out_data), 32'd10);
      applyStimulus(0, 0, 1, 16'd12, 0);
      checkOutput("bp_hold", 32'(out_data), 32'd10);
      applyStimulus(0, 0, 1, 16'd12, 1);
      checkOutput("bp_rel_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_o10", 32'(out_data), 32'd10);
      applyStimulus(0, 0, 1, 16'd12, 1);
      checkOutput("bp_o11", 32'(out_data), 32'd11);
      applyStimulus(0, 0, 0, 16'd0, 1);
      checkOutput("bp_o12", 32'(out_data), 32'd12);
      applyStimulus(0, 0, 0, 16'd0, 0);
      checkOutput("bp_empty", 32'(out_valid), 32'd0);
`else
      // Single-entry: stall is combinational, fire and load share one edge.
      applyStimulus(0, 0, 1, 16'd7, 0);
      applyStimulus(0, 0, 0, 16'd0, 0);
      checkOutput("ns_hold7", 32'(out_data), 32'd7);
      checkOutput("ns_ready0", 32'(in_ready), 32'd0);
      applyStimulus(0, 0, 1, 16'd8, 1);
      checkOutput("ns_ready1", 32'(in_ready), 32'd1);
      checkOutput("ns_fire7", 32'(out_data), 32'd7);
      applyStimulus(0, 0, 0, 16'd0, 0);
      checkOutput("ns_load8", 32'(out_data), 32'd8);
      applyStimulus(0, 0, 0, 16'd0, 1);
      applyStimulus(0, 0, 0, 16'd0, 0);
      checkOutput("ns_empty", 32'(out_valid), 32'd0);
`endif

      // Flush discards the held 0x55 and the 0x66 accepted in the same cycle.
      applyStimulus(0, 0, 1, 16'h55, 0);
      applyStimulus(0, 1, 1, 16'h66, 1);
      checkOutput("fl_before", 32'(out_data), 32'h55);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("fl_valid", 32'(out_valid), 32'd0);
      checkOutput("fl_data", 32'(out_data), 32'd0);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("fl_no66", 32'(out_data), 32'd0);

      // Bubble counter saturation, survives flush, cleared by reset.
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 16'h0, 1);
      applyStimulus(0, 1, 0, 16'h0, 0);
      checkOutput("bc_sat", 32'(bubble_cnt), 32'd15);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("bc_flush", 32'(bubble_cnt), 32'd15);
      applyStimulus(1, 0, 0, 16'h0, 0);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("bc_reset", 32'(bubble_cnt), 32'd0);

      // Reset mid-operation loses the held entry.
      applyStimulus(0, 0, 1, 16'd9, 0);
      applyStimulus(1, 0, 1, 16'd9, 0);
      checkOutput("mr_ready", 32'(in_ready), 32'd0);
      checkOutput("mr_held", 32'(out_data), 32'd9);
      applyStimulus(0, 0, 0, 16'd0, 0);
      checkOutput("mr_lost", 32'(out_valid), 32'd0);
      applyStimulus(0, 0, 0, 16'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
